// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// sequential-fetch increment and the default boot address.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_incr.sv
// Sequential fetch address: pc + 4, wrapping naturally at 2^32.
module pc_incr
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    output logic [31:0] pc_next
);

    // 32-bit add drops the carry, so 32'hFFFF_FFFC rolls over to 0
    assign pc_next = pc + PC_INC;

endmodule

// File: rtl/pc_fetch_unit.sv
// Single-outstanding-request instruction fetch unit. Issues one word fetch
// at a time, presents the returned word downstream, holds it while stalled
// and squashes in-flight fetches on a redirect.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misaligned_err
);

    fetch_state_t state, state_n;
    logic [31:0]  fetch_pc, fetch_pc_n;
    logic [31:0]  pc_plus4;
    logic         kill, kill_n;
    logic [31:0]  kill_pc, kill_pc_n;
    logic [31:0]  instr_n, instr_pc_n;
    logic         instr_valid_n;
    logic         err_n;
    logic         redir_ok;

    pc_incr u_pc_incr (
        .pc      (fetch_pc),
        .pc_next (pc_plus4)
    );

    // Misaligned targets are dropped outright; only aligned ones steer fetch
    assign redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
    assign imem_req  = (state == ST_REQ);
    assign imem_addr = fetch_pc;

    // Next-state and datapath updates; defaults hold everything
    always_comb begin
        state_n       = state;
        fetch_pc_n    = fetch_pc;
        kill_n        = kill;
        kill_pc_n     = kill_pc;
        instr_n       = instr;
        instr_pc_n    = instr_pc;
        instr_valid_n = instr_valid;
        err_n         = redirect_valid && (redirect_target[1:0] != 2'b00);

        // Downstream took the instruction; a capture below may refill it
        if (instr_valid && !stall)
            instr_valid_n = 1'b0;

        case (state)
            ST_IDLE: begin
                state_n = ST_REQ;
                if (redir_ok)
                    fetch_pc_n = redirect_target;
            end
            ST_REQ: begin
                if (redir_ok) begin
                    instr_valid_n = 1'b0;
                    if (imem_ack) begin
                        // Data arriving this cycle belongs to the old path
                        fetch_pc_n = redirect_target;
                        kill_n     = 1'b0;
                    end else begin
                        // Keep the bus request stable; remember where to go
                        kill_n    = 1'b1;
                        kill_pc_n = redirect_target;
                    end
                end else if (imem_ack) begin
                    if (kill) begin
                        fetch_pc_n = kill_pc;
                        kill_n     = 1'b0;
                    end else begin
                        instr_n       = imem_rdata;
                        instr_pc_n    = fetch_pc;
                        instr_valid_n = 1'b1;
                        fetch_pc_n    = pc_plus4;
                        if (stall)
                            state_n = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redir_ok) begin
                    instr_valid_n = 1'b0;
                    fetch_pc_n    = redirect_target;
                    state_n       = ST_REQ;
                end else if (!stall) begin
                    state_n = ST_REQ;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            fetch_pc       <= RESET_PC;
            kill           <= 1'b0;
            kill_pc        <= 32'h0;
            instr          <= 32'h0;
            instr_pc       <= 32'h0;
            instr_valid    <= 1'b0;
            misaligned_err <= 1'b0;
        end else begin
            state          <= state_n;
            fetch_pc       <= fetch_pc_n;
            kill           <= kill_n;
            kill_pc        <= kill_pc_n;
            instr          <= instr_n;
            instr_pc       <= instr_pc_n;
            instr_valid    <= instr_valid_n;
            misaligned_err <= err_n;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, imem_ack;
    logic [31:0] redirect_target, imem_rdata;
    logic        imem_req, instr_valid, misaligned_err;
    logic [31:0] imem_addr, instr, instr_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .misaligned_err  (misaligned_err)
    );

    // Behavioural model: phase 0 = boot gap, 1 = fetching, 2 = holding.
    // A pending squash is a one-entry queue of the target to resume at.
    int          m_phase;
    logic [31:0] m_pc, m_instr, m_ipc;
    bit          m_valid, m_err;
    logic [31:0] m_kill[$];

    task automatic cyc(input bit r, input bit st, input bit rv, input logic [31:0] rt,
                       input bit ak, input logic [31:0] rd);
        bit good, consumed;
        reset = r; stall = st; redirect_valid = rv; redirect_target = rt;
        imem_ack = ak; imem_rdata = rd;
        @(posedge clk);
        if (r) begin
            m_phase = 0; m_pc = 32'h0; m_kill.delete();
            m_valid = 0; m_instr = 0; m_ipc = 0; m_err = 0;
        end else begin
            good     = rv && (rt % 4 == 0);
            consumed = m_valid && !st;
            m_err    = rv && (rt % 4 != 0);
            if (m_phase == 0) begin
                m_phase = 1;
                if (good) m_pc = rt;
            end else if (m_phase == 1) begin
                if (good) begin
                    m_valid = 0;
                    m_kill.delete();
                    if (ak) m_pc = rt;
                    else    m_kill.push_back(rt);
                end else if (ak && m_kill.size() != 0) begin
                    m_pc = m_kill.pop_front();
                    if (consumed) m_valid = 0;
                end else if (ak) begin
                    m_instr = rd; m_ipc = m_pc; m_valid = 1;
                    m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
                    if (st) m_phase = 2;
                end else if (consumed) begin
                    m_valid = 0;
                end
            end else begin
                if (good) begin
                    m_valid = 0; m_pc = rt; m_phase = 1;
                end else if (!st) begin
                    m_valid = 0; m_phase = 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 32'h40, 1, 32'h1234);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h/%h want 0/0", instr, instr_pc); end
        checks++; if (misaligned_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", misaligned_err); end
    endtask

    task automatic test_back_to_back();
        cyc(0, 0, 0, 0, 1, 32'hFFFF_0000);   // boot gap, ack ignored
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_first_req: req=%b addr=%h valid=%b want 1/0/0", imem_req, imem_addr, instr_valid); end
        cyc(0, 0, 0, 0, 1, 32'h00A0_0093);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h00A0_0093 || instr_pc !== 32'h0) begin errors++; $display("FAIL b2b_i0: valid=%b instr=%h pc=%h", instr_valid, instr, instr_pc); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL b2b_addr4: got %b/%h want 1/4", imem_req, imem_addr); end
        cyc(0, 0, 0, 0, 1, 32'h0010_8113);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h0010_8113 || instr_pc !== 32'h4) begin errors++; $display("FAIL b2b_i1: valid=%b instr=%h pc=%h", instr_valid, instr, instr_pc); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL b2b_addr8: got %h want 8", imem_addr); end
    endtask

    task automatic test_stall_hold();
        cyc(0, 1, 0, 0, 1, 32'hC0DE_0008);
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr !== 32'hC0DE_0008 || instr_pc !== 32'h8) begin errors++; $display("FAIL hold_%0d: req=%b valid=%b instr=%h pc=%h", i, imem_req, instr_valid, instr, instr_pc); end
            if (i < 2) cyc(0, 1, 0, 0, 1, $urandom);
        end
        cyc(0, 0, 0, 0, 0, 0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || instr_valid !== 1'b0) begin errors++; $display("FAIL hold_release: req=%b addr=%h valid=%b want 1/c/0", imem_req, imem_addr, instr_valid); end
    endtask

    task automatic test_redirect_kill();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h1111_1111);
        cyc(0, 0, 0, 0, 1, 32'h2222_2222);
        cyc(0, 0, 1, 32'h100, 0, 0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin errors++; $display("FAIL kill_stable: req=%b addr=%h valid=%b want 1/8/0", imem_req, imem_addr, instr_valid); end
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL kill_discard: valid=%b addr=%h req=%b want 0/100/1", instr_valid, imem_addr, imem_req); end
        cyc(0, 0, 0, 0, 1, 32'h3333_3333);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'h3333_3333) begin errors++; $display("FAIL kill_resume: valid=%b pc=%h instr=%h", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_misaligned();
        cyc(0, 0, 1, 32'h102, 0, 0);
        checks++; if (misaligned_err !== 1'b1 || imem_addr !== 32'h104 || imem_req !== 1'b1) begin errors++; $display("FAIL mis_pulse: err=%b addr=%h req=%b want 1/104/1", misaligned_err, imem_addr, imem_req); end
        cyc(0, 0, 0, 0, 1, 32'h4444_4444);
        checks++; if (misaligned_err !== 1'b0) begin errors++; $display("FAIL mis_one_cycle: err=%b want 0", misaligned_err); end
        checks++; if (instr_pc !== 32'h104 || imem_addr !== 32'h108) begin errors++; $display("FAIL mis_seq: pc=%h addr=%h want 104/108", instr_pc, imem_addr); end
    endtask

    task automatic test_wrap();
        cyc(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h5555_5555);
        checks++; if (imem_addr !== 32'hFFFF_FFFC || instr_valid !== 1'b0) begin errors++; $display("FAIL wrap_redir: addr=%h valid=%b want fffffffc/0", imem_addr, instr_valid); end
        cyc(0, 0, 0, 0, 1, 32'h6666_6666);
        checks++; if (instr_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: pc=%h addr=%h want fffffffc/0", instr_pc, imem_addr); end
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 0, 0, 0, 0);
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL rmid_reset: req=%b valid=%b instr=%h pc=%h", imem_req, instr_valid, instr, instr_pc); end
        cyc(0, 0, 0, 0, 1, 32'h7777_7777);   // stale ack lands in the boot gap
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale: req=%b addr=%h valid=%b want 1/0/0", imem_req, imem_addr, instr_valid); end
        cyc(0, 0, 0, 0, 1, 32'h8888_8888);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h8888_8888) begin errors++; $display("FAIL rmid_first: valid=%b pc=%h instr=%h", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_random();
        bit r, st, rv, ak;
        logic [31:0] rt;
        for (int n = 0; n < 800; n++) begin
            r  = ($urandom_range(99) < 2);
            st = ($urandom_range(99) < 30);
            rv = ($urandom_range(99) < 12);
            ak = ($urandom_range(99) < 60);
            case ($urandom_range(2))
                0: rt = {$urandom_range(32'h3FFF_FFFF), 2'b00};
                1: begin rt = $urandom; if (rt[1:0] == 2'b00) rt[0] = 1'b1; end
                default: rt = 32'hFFFF_FFFC;
            endcase
            cyc(r, st, rv, rt, ak, $urandom);
            checks++; if (imem_req !== (m_phase == 1)) begin errors++; $display("FAIL rnd_req @%0d: got %b want %b", n, imem_req, (m_phase == 1)); end
            if (m_phase == 1) begin
                checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr @%0d: got %h want %h", n, imem_addr, m_pc); end
            end
            checks++; if (instr_valid !== m_valid) begin errors++; $display("FAIL rnd_valid @%0d: got %b want %b", n, instr_valid, m_valid); end
            checks++; if (instr !== m_instr || instr_pc !== m_ipc) begin errors++; $display("FAIL rnd_instr @%0d: got %h/%h want %h/%h", n, instr, instr_pc, m_instr, m_ipc); end
            checks++; if (misaligned_err !== m_err) begin errors++; $display("FAIL rnd_err @%0d: got %b want %b", n, misaligned_err, m_err); end
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        test_reset();
        test_back_to_back();
        test_stall_hold();
        test_redirect_kill();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  downstream not ready; holds the presented instruction.
REQ-005 redirect_valid  input  1  branch/jump taken this cycle.
REQ-006 redirect_target  input  32  new fetch address when redirect_valid=1.
REQ-007 imem_req  output  1  fetch request to instruction memory.
REQ-008 imem_addr  output  32  word-aligned fetch address.
REQ-009 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 instr_valid  output  1  instr/instr_pc hold a valid instruction.
REQ-012 instr  output  32  fetched instruction.
REQ-013 instr_pc  output  32  address instr was fetched from.
REQ-014 misaligned_err  output  1  one-cycle pulse: redirect_target[1:0]!=0, redirect ignored.

Function
REQ-015 The block SHALL implement FSM states IDLE, REQ, HOLD; reset state IDLE.
REQ-016 IDLE SHALL last exactly one cycle with imem_req=0, then go to REQ with fetch PC=RESET_PC.
REQ-017 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal fetch PC, both stable until the cycle imem_ack=1.
REQ-018 On imem_ack in REQ (no kill pending), the block SHALL register instr=imem_rdata, instr_pc=fetch PC, instr_valid=1 next cycle, and update fetch PC to fetch PC+4.
REQ-019 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 After capture, if stall=0 the FSM SHALL return to REQ immediately (one instruction per ack, back-to-back when imem_ack is held high); if stall=1 it SHALL enter HOLD.
REQ-021 In HOLD, imem_req SHALL be 0 and instr/instr_pc/instr_valid SHALL be held unchanged; on stall=0 go to REQ next cycle.
REQ-022 When a valid instruction is consumed (instr_valid=1, stall=0) and no new capture occurs, instr_valid SHALL fall to 0 the next cycle.
REQ-023 redirect_valid with aligned target SHALL have priority over PC+4: fetch PC := redirect_target, instr_valid := 0 next cycle.
REQ-024 Redirect while a request is outstanding (REQ, imem_ack=0) SHALL set a kill flag; imem_req/imem_addr stay unchanged until ack; the acked data SHALL be discarded; the next request uses redirect_target.
REQ-025 Redirect in the same cycle as imem_ack SHALL discard that ack's data; the next request uses redirect_target.
REQ-026 Redirect in HOLD SHALL drop the held instruction and go to REQ at the target regardless of stall.
REQ-027 A second redirect before the killed ack arrives SHALL overwrite the pending target (last wins).
REQ-028 Misaligned redirect_target SHALL be ignored entirely and SHALL pulse misaligned_err=1 for one cycle.
REQ-029 imem_ack outside REQ SHALL be ignored.

Reset
REQ-030 On reset=1 at a clock edge: state=IDLE, fetch PC=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, misaligned_err=0, kill flag=0.
REQ-031 Reset SHALL override every other input, including mid-request; any later imem_ack for the aborted request is ignored (state IDLE).

Structure
REQ-032 The FSM state encoding, the constant 32'd4 increment, and the RESET_PC default SHALL live in a shared package (fetch_pkg).
REQ-033 The +4 increment SHALL be a single instantiated sub-module, pc_incr (32-bit adder, constant operand 4), not inline arithmetic.

Verification
REQ-034 Reset, then imem_ack held 1 returning 0x00A00093, 0x00108113 -> imem_addr 0x0, 0x4, 0x8; instr_pc 0x0 then 0x4 on consecutive cycles.
REQ-035 Ack with stall=1 for 3 cycles -> instr_valid=1, instr/instr_pc constant, imem_req=0 for 3 cycles, then request to the next PC.
REQ-036 Redirect to 0x100 while request at 0x8 outstanding, ack after 2 cycles -> 0x8 data never valid; next imem_addr=0x100.
REQ-037 Redirect to 0x102 -> misaligned_err one-cycle pulse; fetch sequence unchanged.
REQ-038 Redirect to 0xFFFF_FFFC then ack -> next imem_addr=0x0000_0000.
REQ-039 Reset asserted during outstanding request, stale ack next cycle -> outputs at reset values; first request at RESET_PC after IDLE.
